sccb_slave_responder: RTL and testbench

SCCB responder (slave end) for the SCCB bus driven by `sccb_master_controller`. It oversamples `sio_c`/`sio_d` on the internal clock and decodes START/STOP, the device ID, the sub-address and the data phases. It acknowledges its own ID and exposes a simple register-file port, so a single-clock design can emulate a camera sensor for system benches or FPGA loopback.

---
 rtl/sccb_slave_responder_if.sv | 30 +++
 rtl/sccb_slave_responder.sv | 235 +++++++++++++++++++++++
 tb/tb_sccb_slave_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_slave_responder_if.sv
// Register-file side of the SCCB responder: address/data/strobes toward a
// register bank, read data back from it, and a bus-activity flag.
interface sccb_slave_responder_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] reg_addr_o;
  logic [DATA_W-1:0] reg_wdata_o;
  logic              reg_wr_o;
  logic              reg_rd_o;
  logic [DATA_W-1:0] reg_rdata_i;
  logic              busy_o;

  modport slave (
    output reg_addr_o,
    output reg_wdata_o,
    output reg_wr_o,
    output reg_rd_o,
    output busy_o,
    input  reg_rdata_i
  );

  modport master (
    input  reg_addr_o,
    input  reg_wdata_o,
    input  reg_wr_o,
    input  reg_rd_o,
    input  busy_o,
    output reg_rdata_i
  );
endinterface

// File: rtl/sccb_slave_responder.sv
// SCCB responder: oversamples sio_c/sio_d on clk, decodes START/STOP, ID,
// sub-address and data bytes, and drives sio_d only low or Z.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | bus free, waiting for START
// ST_ID     | shifting device ID + R/W, ack slot if ID matches
// ST_SUB    | shifting sub-address into addr_ptr, then ack
// ST_WDATA  | shifting write data, write strobe + ack
// ST_RDATA  | shifting read data out, master NA ignored
// ST_IGNORE | not addressed / transfer done, wait for START or STOP
//
// bit_cnt counts sc_rise events within a byte (0..8). slot_q marks the
// span of the 9th bit, from the sc_fall ending bit 8 to the sc_fall ending
// bit 9, so both falls at bit_cnt==8 can be told apart.
module sccb_slave_responder #(
  parameter logic [6:0] SLV_DVC_ADDR = 7'h21,
  parameter int         DATA_W       = 8,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sio_c,
  inout  wire                  sio_d,
  sccb_slave_responder_if.slave rf
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID,
    ST_SUB,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] sc_sync_q;
  logic [SYNC_STAGES-1:0] sd_sync_q;
  logic                   sc_prev_q;
  logic                   sd_prev_q;
  logic                   sc_s;
  logic                   sd_s;
  logic                   sc_rise;
  logic                   sc_fall;
  logic                   start_det;
  logic                   stop_det;

  state_t            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              slot_q, slot_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              cap_q, cap_d;
  logic              drive_q, drive_d;

  // Synchronizers plus one edge-detect stage; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_sync_q <= '1;
      sd_sync_q <= '1;
      sc_prev_q <= 1'b1;
      sd_prev_q <= 1'b1;
    end else begin
      sc_sync_q <= {sc_sync_q[SYNC_STAGES-2:0], sio_c};
      sd_sync_q <= {sd_sync_q[SYNC_STAGES-2:0], sio_d};
      sc_prev_q <= sc_sync_q[SYNC_STAGES-1];
      sd_prev_q <= sd_sync_q[SYNC_STAGES-1];
    end
  end

  assign sc_s      = sc_sync_q[SYNC_STAGES-1];
  assign sd_s      = sd_sync_q[SYNC_STAGES-1];
  assign sc_rise   = sc_s & ~sc_prev_q;
  assign sc_fall   = ~sc_s & sc_prev_q;
  assign start_det = sc_s & sd_prev_q & ~sd_s;
  assign stop_det  = sc_s & ~sd_prev_q & sd_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      slot_q    <= 1'b0;
      shift_q   <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      cap_q     <= 1'b0;
      drive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      slot_q    <= slot_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cap_q     <= cap_d;
      drive_q   <= drive_d;
    end
  end

  // Next-state logic: START/STOP first, then per-state bit handling.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    slot_d    = slot_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    cap_d     = rd_q;
    drive_d   = drive_q;

    // Read data is valid the cycle after the read strobe.
    if (cap_q) begin
      tx_d = rf.reg_rdata_i;
    end

    if (start_det) begin
      state_d   = ST_ID;
      bit_cnt_d = 4'd0;
      slot_d    = 1'b0;
      drive_d   = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      slot_d    = 1'b0;
      drive_d   = 1'b0;
    end else begin
      if ((state_q == ST_ID) || (state_q == ST_SUB) ||
          (state_q == ST_WDATA) || (state_q == ST_RDATA)) begin
        if (sc_rise && (bit_cnt_q < 4'd8)) begin
          shift_d   = {shift_q[DATA_W-2:0], sd_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end

      unique case (state_q)
        ST_ID: begin
          if (sc_rise && slot_q && shift_q[0]) begin
            rd_d = 1'b1;
          end else if (sc_fall && (bit_cnt_q == 4'd8)) begin
            if (!slot_q) begin
              if (shift_q[7:1] == SLV_DVC_ADDR) begin
                slot_d  = 1'b1;
                drive_d = 1'b1;
              end else begin
                state_d = ST_IGNORE;
              end
            end else begin
              slot_d    = 1'b0;
              bit_cnt_d = 4'd0;
              if (shift_q[0]) begin
                // Ack release and bit 7 launch share this fall.
                state_d = ST_RDATA;
                drive_d = ~tx_q[7];
              end else begin
                state_d = ST_SUB;
                drive_d = 1'b0;
              end
            end
          end
        end
        ST_SUB: begin
          if (sc_fall && (bit_cnt_q == 4'd8)) begin
            if (!slot_q) begin
              addr_d  = shift_q;
              slot_d  = 1'b1;
              drive_d = 1'b1;
            end else begin
              state_d   = ST_WDATA;
              slot_d    = 1'b0;
              bit_cnt_d = 4'd0;
              drive_d   = 1'b0;
            end
          end
        end
        ST_WDATA: begin
          if (sc_fall && (bit_cnt_q == 4'd8)) begin
            if (!slot_q) begin
              wdata_d = shift_q;
              wr_d    = 1'b1;
              slot_d  = 1'b1;
              drive_d = 1'b1;
            end else begin
              state_d   = ST_IGNORE;
              slot_d    = 1'b0;
              bit_cnt_d = 4'd0;
              drive_d   = 1'b0;
            end
          end
        end
        ST_RDATA: begin
          if (sc_fall) begin
            if (bit_cnt_q == 4'd8) begin
              drive_d = 1'b0;
            end else if (bit_cnt_q != 4'd0) begin
              drive_d = ~tx_q[3'd7 - bit_cnt_q[2:0]];
            end
          end else if (sc_rise && (bit_cnt_q == 4'd8)) begin
            // Master NA sampled here and deliberately ignored.
            state_d   = ST_IGNORE;
            bit_cnt_d = 4'd0;
          end
        end
        ST_IDLE, ST_IGNORE: begin
          drive_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          drive_d = 1'b0;
        end
      endcase
    end
  end

  assign sio_d          = drive_q ? 1'b0 : 1'bz;
  assign rf.reg_addr_o  = addr_q;
  assign rf.reg_wdata_o = wdata_q;
  assign rf.reg_wr_o    = wr_q;
  assign rf.reg_rd_o    = rd_q;
  assign rf.busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sccb_slave_responder.sv
// Bench for sccb_slave_responder: bit-level SCCB master tasks, a strobe
// scoreboard fed by the stimulus, and a monitor that pops on each strobe.
module tb_sccb_slave_responder;

  localparam int Q = 10;

  logic clk;
  logic rst_n;
  logic sio_c;
  logic m_low;
  wire  sio_d;

  pullup (sio_d);
  assign sio_d = m_low ? 1'b0 : 1'bz;

  sccb_slave_responder_if #(.DATA_W(8)) rf_if ();

  sccb_slave_responder #(
    .SLV_DVC_ADDR(7'h21),
    .DATA_W(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sio_c(sio_c),
    .sio_d(sio_d),
    .rf(rf_if)
  );

  typedef struct packed {
    logic       is_rd;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   drive_viol = 0;
  logic no_drive_win = 1'b0;
  logic prev_strobe = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Scoreboard monitor: every strobe must match the next expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rf_if.reg_wr_o || rf_if.reg_rd_o) begin
      chk("strobe_width", {31'd0, prev_strobe}, 32'd0);
      if (sb.size() == 0) begin
        chk("strobe_unexpected", {30'd0, rf_if.reg_rd_o, rf_if.reg_wr_o}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind", {31'd0, rf_if.reg_rd_o}, {31'd0, e.is_rd});
        chk("strobe_addr", {24'd0, rf_if.reg_addr_o}, {24'd0, e.addr});
        if (!e.is_rd) chk("wr_data", {24'd0, rf_if.reg_wdata_o}, {24'd0, e.data});
      end
    end
    prev_strobe = rf_if.reg_wr_o | rf_if.reg_rd_o;
  end

  // Counts cycles where the DUT pulls sio_d low inside a no-drive window.
  always @(posedge clk) begin
    if (no_drive_win && !m_low && (sio_d === 1'b0)) drive_viol++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_low = 1'b1; tick(2*Q); sio_c = 1'b0; tick(Q);
  endtask

  task automatic bus_rstart();
    m_low = 1'b0; tick(Q); sio_c = 1'b1; tick(Q); m_low = 1'b1; tick(Q); sio_c = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    m_low = 1'b1; tick(Q); sio_c = 1'b1; tick(Q); m_low = 1'b0; tick(2*Q);
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; tick(Q); sio_c = 1'b1; tick(2*Q); sio_c = 1'b0; tick(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_low = 1'b0; tick(Q); sio_c = 1'b1; tick(Q); b = sio_d; tick(Q); sio_c = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] v, input logic exp_ack, input string nm);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(a);
    chk(nm, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic read_byte(input logic [7:0] exp, input string nm);
    logic [7:0] got;
    logic       b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      got[i] = b;
    end
    chk(nm, {24'd0, got}, {24'd0, exp});
    recv_bit(b);
    chk({nm, "_na_released"}, {31'd0, b}, 32'd1);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.is_rd = 1'b0; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic push_rd(input logic [7:0] a);
    exp_t e;
    e.is_rd = 1'b1; e.addr = a; e.data = 8'h00;
    sb.push_back(e);
  endtask

  initial begin
    int viol0;
    sio_c = 1'b1;
    m_low = 1'b0;
    rst_n = 1'b0;
    rf_if.reg_rdata_i = 8'h00;
    tick(5);
    rst_n = 1'b1;
    tick(5);

    chk("rst_addr", {24'd0, rf_if.reg_addr_o}, 32'd0);
    chk("rst_wdata", {24'd0, rf_if.reg_wdata_o}, 32'd0);
    chk("rst_strobes", {30'd0, rf_if.reg_wr_o, rf_if.reg_rd_o}, 32'd0);
    chk("rst_busy", {31'd0, rf_if.busy_o}, 32'd0);
    chk("rst_sio_d", {31'd0, sio_d}, 32'd1);

    // 3-phase write 0x42 0x12 0x80
    push_wr(8'h12, 8'h80);
    bus_start();
    chk("w3_busy", {31'd0, rf_if.busy_o}, 32'd1);
    write_byte(8'h42, 1'b0, "w3_ack_id");
    write_byte(8'h12, 1'b0, "w3_ack_sub");
    write_byte(8'h80, 1'b0, "w3_ack_data");
    bus_stop();
    chk("w3_busy_after", {31'd0, rf_if.busy_o}, 32'd0);
    chk("w3_sb_empty", sb.size(), 32'd0);

    // 2-phase write then read of 0x76
    bus_start();
    write_byte(8'h42, 1'b0, "w2_ack_id");
    write_byte(8'h0A, 1'b0, "w2_ack_sub");
    bus_stop();
    chk("w2_addr", {24'd0, rf_if.reg_addr_o}, 32'h0A);
    rf_if.reg_rdata_i = 8'h76;
    push_rd(8'h0A);
    bus_start();
    write_byte(8'h43, 1'b0, "rd_ack_id");
    read_byte(8'h76, "rd_data");
    bus_stop();
    chk("rd_busy_after", {31'd0, rf_if.busy_o}, 32'd0);
    chk("rd_sb_empty", sb.size(), 32'd0);

    // Wrong ID: no ack, no drive, no strobes
    viol0 = drive_viol;
    no_drive_win = 1'b1;
    bus_start();
    write_byte(8'h60, 1'b1, "wid_nack_id");
    write_byte(8'h12, 1'b1, "wid_nack_sub");
    write_byte(8'h55, 1'b1, "wid_nack_data");
    bus_stop();
    no_drive_win = 1'b0;
    chk("wid_no_drive", drive_viol - viol0, 32'd0);
    chk("wid_addr_kept", {24'd0, rf_if.reg_addr_o}, 32'h0A);

    // Early STOP after 4 bits of write data
    bus_start();
    write_byte(8'h42, 1'b0, "es_ack_id");
    write_byte(8'h33, 1'b0, "es_ack_sub");
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_stop();
    chk("es_busy", {31'd0, rf_if.busy_o}, 32'd0);
    chk("es_sio_d", {31'd0, sio_d}, 32'd1);
    chk("es_addr", {24'd0, rf_if.reg_addr_o}, 32'h33);
    chk("es_sb_empty", sb.size(), 32'd0);

    // Repeated START mid-SUB, then read with previous pointer
    rf_if.reg_rdata_i = 8'hA5;
    bus_start();
    write_byte(8'h42, 1'b0, "rs_ack_id");
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    push_rd(8'h33);
    bus_rstart();
    write_byte(8'h43, 1'b0, "rs_ack_rid");
    read_byte(8'hA5, "rs_data");
    bus_stop();
    chk("rs_addr", {24'd0, rf_if.reg_addr_o}, 32'h33);
    chk("rs_sb_empty", sb.size(), 32'd0);

    // Reset while the DUT drives bit 5 (0x5A -> bits 0,1,0,...)
    begin
      logic b;
      rf_if.reg_rdata_i = 8'h5A;
      push_rd(8'h33);
      bus_start();
      write_byte(8'h43, 1'b0, "mr_ack_id");
      recv_bit(b);
      chk("mr_bit7", {31'd0, b}, 32'd0);
      recv_bit(b);
      chk("mr_bit6", {31'd0, b}, 32'd1);
      chk("mr_driving_bit5", {31'd0, sio_d}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_sio_d_released", {31'd0, sio_d}, 32'd1);
      chk("mr_addr", {24'd0, rf_if.reg_addr_o}, 32'd0);
      chk("mr_wdata", {24'd0, rf_if.reg_wdata_o}, 32'd0);
      chk("mr_strobes", {30'd0, rf_if.reg_wr_o, rf_if.reg_rd_o}, 32'd0);
      chk("mr_busy", {31'd0, rf_if.busy_o}, 32'd0);
      sio_c = 1'b1;
      m_low = 1'b0;
      tick(5);
      rst_n = 1'b1;
      tick(5);
    end
    chk("mr_sb_empty", sb.size(), 32'd0);

    push_wr(8'h05, 8'hC3);
    bus_start();
    write_byte(8'h42, 1'b0, "pr_ack_id");
    write_byte(8'h05, 1'b0, "pr_ack_sub");
    write_byte(8'hC3, 1'b0, "pr_ack_data");
    bus_stop();
    chk("pr_addr", {24'd0, rf_if.reg_addr_o}, 32'h05);
    chk("pr_busy", {31'd0, rf_if.busy_o}, 32'd0);

    tick(20);
    chk("final_sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
